// File: rtl/pwm_word_loader_pkg.sv
// Shared frame layout and FSM encoding for the PWM timing-word loader.
// Frame = {addr[2:0], reserved[1:0], payload[10:0]}, shifted in MSB first.
package pwm_word_loader_pkg;

  localparam int FRAME_W = 16;
  localparam int ADDR_HI = 15;
  localparam int ADDR_LO = 13;
  localparam int RSV_HI  = 12;
  localparam int RSV_LO  = 11;
  localparam int PAY_LO  = 0;
  localparam int ADDR_W  = ADDR_HI - ADDR_LO + 1;
  localparam int RSV_W   = RSV_HI - RSV_LO + 1;
  localparam int CNT_W   = 5;

  localparam logic [CNT_W-1:0] CNT_SAT = 5'd17;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_CHECK,
    ST_PEND,
    ST_COMMIT
  } state_t;

  // Bit counter stops at one past a full frame so overlong frames stay detectable.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_SAT) ? c : c + 5'd1;
  endfunction

endpackage

// File: rtl/pwm_sync_edge.sv
// Level synchroniser for an asynchronous pin with registered edge pulses.
// Rise/fall pulses line up with the first cycle the new level appears on o_lvl; no backpressure.
module pwm_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_lvl,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_rise;
  logic              r_fall;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      // Compare the next level against the current one so the pulse is aligned with o_lvl.
      r_rise <= r_sync[STAGES-2] & ~r_sync[STAGES-1];
      r_fall <= ~r_sync[STAGES-2] & r_sync[STAGES-1];
    end
  end

  assign o_lvl  = r_sync[STAGES-1];
  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/pwm_word_loader.sv
// SPI-style receiver that loads 11-bit timing words into one of NUM_TARGETS registers on PWM period end.
// NCS rise to CHECK in SYNC_STAGES+1 cycles; PERIOD_END to ENA in 1 cycle; no backpressure, a replaced word raises OVERRUN.
module pwm_word_loader
  import pwm_word_loader_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_TARGETS = 5,
  parameter int DATA_W      = 11
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_sck,
  input  logic                   i_sdi,
  input  logic                   i_ncs,
  input  logic                   i_period_end,
  output logic [DATA_W-1:0]      o_data,
  output logic [NUM_TARGETS-1:0] o_ena,
  output logic                   o_frame_err,
  output logic                   o_overrun
);

  logic w_sck_lvl, w_sck_rise, w_unused_sck_fall;
  logic w_sdi_lvl, w_unused_sdi_rise, w_unused_sdi_fall;
  logic w_ncs_lvl, w_ncs_rise, w_ncs_fall;

  pwm_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sck (
    .i_clk(i_clk), .i_rst(i_rst), .i_d(i_sck),
    .o_lvl(w_sck_lvl), .o_rise(w_sck_rise), .o_fall(w_unused_sck_fall)
  );

  pwm_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sdi (
    .i_clk(i_clk), .i_rst(i_rst), .i_d(i_sdi),
    .o_lvl(w_sdi_lvl), .o_rise(w_unused_sdi_rise), .o_fall(w_unused_sdi_fall)
  );

  pwm_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ncs (
    .i_clk(i_clk), .i_rst(i_rst), .i_d(i_ncs),
    .o_lvl(w_ncs_lvl), .o_rise(w_ncs_rise), .o_fall(w_ncs_fall)
  );

  state_t                  r_state, w_next;
  logic [FRAME_W-1:0]      r_shift;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_pend;
  logic [ADDR_W-1:0]       r_pend_addr;
  logic [DATA_W-1:0]       r_pend_data;
  logic [DATA_W-1:0]       r_data;
  logic [NUM_TARGETS-1:0]  r_ena;
  logic                    r_frame_err;
  logic                    r_overrun;

  logic [ADDR_W-1:0]       w_addr;
  logic [RSV_W-1:0]        w_rsv;
  logic                    w_good;
  logic                    w_commit;
  logic                    w_shift_en;
  logic [NUM_TARGETS-1:0]  w_onehot;

  assign w_addr     = r_shift[ADDR_HI:ADDR_LO];
  assign w_rsv      = r_shift[RSV_HI:RSV_LO];
  assign w_good     = (r_cnt == CNT_W'(FRAME_W)) && (32'(w_addr) < NUM_TARGETS) && (w_rsv == '0);
  // Commit is decoupled from the FSM so a pending word can go out while the next frame shifts in.
  assign w_commit   = r_pend & i_period_end;
  assign w_shift_en = (r_state == ST_SHIFT) & w_sck_rise & ~w_ncs_lvl;
  assign w_onehot   = NUM_TARGETS'(1) << r_pend_addr;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_ncs_fall) w_next = ST_SHIFT;
      ST_SHIFT:  if (w_ncs_rise) w_next = ST_CHECK;
      ST_CHECK:  w_next = w_good ? ST_PEND : ST_IDLE;
      ST_PEND: begin
        if (w_ncs_fall)        w_next = ST_SHIFT;
        else if (i_period_end) w_next = ST_COMMIT;
      end
      ST_COMMIT: w_next = w_ncs_fall ? ST_SHIFT : ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shift     <= '0;
      r_cnt       <= '0;
      r_pend      <= 1'b0;
      r_pend_addr <= '0;
      r_pend_data <= '0;
      r_data      <= '0;
      r_ena       <= '0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_ena <= '0;
      if (w_ncs_fall && (w_next == ST_SHIFT)) begin
        r_shift <= '0;
        r_cnt   <= '0;
      end else if (w_shift_en) begin
        r_shift <= {r_shift[FRAME_W-2:0], w_sdi_lvl};
        r_cnt   <= cnt_inc(r_cnt);
      end
      if (w_commit) begin
        r_ena  <= w_onehot;
        r_data <= r_pend_data;
        r_pend <= 1'b0;
      end
      // The word under check is latched after any same-cycle commit of the older word.
      if (r_state == ST_CHECK) begin
        if (w_good) begin
          r_pend      <= 1'b1;
          r_pend_addr <= w_addr;
          r_pend_data <= r_shift[PAY_LO +: DATA_W];
          r_frame_err <= 1'b0;
          if (r_pend && !w_commit) r_overrun <= 1'b1;
        end else begin
          r_frame_err <= 1'b1;
        end
      end
    end
  end

  assign o_data      = r_data;
  assign o_ena       = r_ena;
  assign o_frame_err = r_frame_err;
  assign o_overrun   = r_overrun;

endmodule
